// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: fetch FSM encoding and RV32 constants used by the prefetch unit.
package riscv_pkg;

  localparam int unsigned       XLEN      = 32;
  localparam logic [XLEN-1:0]   INSTR_NOP = 32'h0000_0013;
  localparam int unsigned       PC_STEP   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {instr, pc} words with synchronous flush and an occupancy count.
module prefetch_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [DW-1:0]          rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DW-1:0]    mem_q [DEPTH];
  logic             empty, full, do_wr, do_rd;

  // NOTE: every signal below is assigned before any condition, so no latch can be inferred.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    do_rd    = rd_en && !empty && !flush;
    // A write into a full buffer is legal only when the head leaves in the same cycle.
    do_wr    = wr_en && (!full || do_rd) && !flush;
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the head is zeroed while empty, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: credit-limited word fetch over req/gnt/rvalid, buffered {instr, pc, pc+4} to decode,
// flush and stale-response drain on redirect. Define PREFETCH_STATS_EN to add saturating statistics counters.
module instr_prefetch
  import riscv_pkg::*;
#(
  parameter int unsigned      WIDTH    = XLEN,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
`ifdef PREFETCH_STATS_EN
  output logic [31:0]      stat_fetched,
  output logic [31:0]      stat_flushed,
  output logic [31:0]      stat_stall,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_pc_4
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(PC_STEP);
  localparam logic [CNT_W:0]   CREDITS = (CNT_W + 1)'(DEPTH);

  fetch_state_e       state_q, state_d;
  logic [WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0]   resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     credit_used;
  logic [2*WIDTH-1:0] head_data;
  logic               gnt_acc, rsp_acc, rsp_keep, enq, deq;

  // Bus handshake decode; the request depends only on registered state and fetch_en.
  always_comb begin
    credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
    mem_req     = (state_q == FETCH) && fetch_en && (credit_used < CREDITS);
    gnt_acc     = mem_req && mem_gnt;
    rsp_acc     = mem_rvalid && (outstanding_q != '0);
    rsp_keep    = rsp_acc && (drop_q == '0);
    enq         = rsp_keep && !redirect_valid;
    deq         = out_valid && out_ready && !redirect_valid;
  end

  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(gnt_acc) - CNT_W'(rsp_acc);
    fetch_pc_d    = gnt_acc ? fetch_pc_q + STEP : fetch_pc_q;
    resp_pc_d     = rsp_keep ? resp_pc_q + STEP : resp_pc_q;
    drop_d        = (rsp_acc && (drop_q != '0)) ? drop_q - CNT_W'(1) : drop_q;
    state_d       = state_q;
    case (state_q)
      IDLE:    if (fetch_en) state_d = FETCH;
      FETCH:   if (!fetch_en) state_d = IDLE;
      DRAIN:   if (drop_d == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase
    // Redirect wins: everything still in flight after this cycle's gnt/rvalid becomes stale.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~WIDTH'(3);
      resp_pc_d  = redirect_pc & ~WIDTH'(3);
      drop_d     = outstanding_d;
      state_d    = (outstanding_d != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  prefetch_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .wr_en    (enq),
    .wr_data  ({mem_rdata, resp_pc_q}),
    .rd_en    (deq),
    .rd_valid (out_valid),
    .rd_data  (head_data),
    .count    (fifo_count)
  );

  assign mem_addr  = fetch_pc_q;
  assign out_instr = head_data[2*WIDTH-1:WIDTH];
  assign out_pc    = head_data[WIDTH-1:0];
  assign out_pc_4  = out_pc + STEP;

`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_flushed_q, stat_flushed_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    stat_fetched_d = stat_fetched_q;
    stat_flushed_d = stat_flushed_q;
    stat_stall_d   = stat_stall_q;
    if (enq && (stat_fetched_q != '1)) stat_fetched_d = stat_fetched_q + 32'd1;
    if (redirect_valid && (stat_flushed_q != '1)) stat_flushed_d = stat_flushed_q + 32'd1;
    if (!out_valid && (state_q != IDLE) && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_flushed_q <= stat_flushed_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
  assign stat_stall   = stat_stall_q;
`endif

  // A response with nothing outstanding is a bus protocol violation; the datapath ignores it.
  rsp_protocol: assert property (@(posedge clk) disable iff (!rst) !(mem_rvalid && (outstanding_q == '0)));

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed + randomized bench for instr_prefetch; a queue-based model of requests and buffered words sets expectations.
module tb_instr_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, out_valid;
  logic [31:0] mem_addr, out_instr, out_pc, out_pc_4;

  always #5 clk = ~clk;

  instr_prefetch #(
    .WIDTH    (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_4       (out_pc_4)
  );

  // Reference: every granted request with its address and stale mark, plus the words waiting for decode.
  typedef struct { logic [31:0] addr; int unsigned due; bit stale; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  req_t        inflight[$];
  ent_t        buffer[$];
  logic [31:0] seen_pc[$];
  logic [31:0] next_pc;
  bit          active;
  int unsigned cyc = 0;
  int unsigned gnt_pct = 100, lat_min = 1, lat_max = 1;
  int          n_cmp = 0, n_bad = 0, n_gnt = 0, n_deliv = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    buffer.delete();
    next_pc = RESET_PC;
    active  = 1'b0;
  endtask

  // Asynchronous reset mid-cycle; outputs must collapse at once, and the memory forgets its requests.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    check("rst_mem_req", mem_req, 32'd0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_pc_4", out_pc_4, 32'd4);
    model_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model across the edge.
  task automatic step(input bit fe, input bit rd_v, input logic [31:0] rd_pc, input bit rdy);
    bit          g, rv, exp_req, exp_valid, draining;
    int          stale_n;
    int unsigned lat;
    req_t        r;
    @(negedge clk);
    g  = ($urandom_range(99) < gnt_pct);
    rv = (inflight.size() > 0) && (inflight[0].due <= cyc);
    fetch_en = fe; redirect_valid = rd_v; redirect_pc = rd_pc; out_ready = rdy;
    mem_gnt = g; mem_rvalid = rv;
    mem_rdata = rv ? mem_word(inflight[0].addr) : $urandom();
    #1;
    stale_n = 0;
    foreach (inflight[i]) if (inflight[i].stale) stale_n++;
    draining  = (stale_n > 0);
    exp_req   = active && fe && !draining && ((buffer.size() + inflight.size()) < DEPTH);
    exp_valid = (buffer.size() != 0);
    check("mem_req", mem_req, 32'(exp_req));
    check("mem_addr", mem_addr, next_pc);
    check("out_valid", out_valid, 32'(exp_valid));
    if (exp_valid) begin
      check("out_pc", out_pc, buffer[0].pc);
      check("out_instr", out_instr, buffer[0].instr);
      check("out_pc_4", out_pc_4, buffer[0].pc + 32'd4);
    end
    if (mem_req && mem_gnt) n_gnt++;
    if (out_valid && rdy && !rd_v) begin
      seen_pc.push_back(out_pc);
      n_deliv++;
    end
    @(posedge clk);
    cyc++;
    if (exp_valid && rdy && !rd_v) void'(buffer.pop_front());
    if (rv) begin
      r = inflight.pop_front();
      if (!r.stale && !rd_v) buffer.push_back('{instr: mem_word(r.addr), pc: r.addr});
    end
    if (exp_req && g) begin
      lat = $urandom_range(lat_max, lat_min);
      inflight.push_back('{addr: next_pc, due: cyc + lat - 1, stale: 1'b0});
      next_pc = next_pc + 32'd4;
    end
    if (rd_v) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      buffer.delete();
      next_pc = rd_pc & 32'hFFFF_FFFC;
    end
    active = rd_v || draining || fe;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int          n0, d0, exp_deliv;
    bit          hit;
    logic [31:0] first_pc;

    // 1: streaming with single-cycle memory.
    apply_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    seen_pc.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      first_pc = (i < seen_pc.size()) ? seen_pc[i] : 32'hDEAD_BEEF;
      check("t1_pc_order", first_pc, 32'(4 * i));
    end

    // 2: decode stalled; credits cap grants at DEPTH, one freed slot buys one request.
    apply_reset();
    n0 = n_gnt;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, 1'b0);
    check("t2_grants", 32'(n_gnt - n0), 32'(DEPTH));
    #1 check("t2_req_low", mem_req, 32'd0);
    n0 = n_gnt;
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b0);
    check("t2_one_more", 32'(n_gnt - n0), 32'd1);

    // 3: redirect with two requests in flight; both responses must be dropped.
    apply_reset();
    lat_min = 6; lat_max = 6;
    seen_pc.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
    gnt_pct = 0;
    step(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    #1;
    check("t3_addr", mem_addr, 32'h0000_0100);
    check("t3_req_drain", mem_req, 32'd0);
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 30; i++) begin
      if (seen_pc.size() > 0) break;
      step(1'b1, 1'b0, '0, 1'b1);
    end
    first_pc = (seen_pc.size() > 0) ? seen_pc[0] : 32'hDEAD_BEEF;
    check("t3_first_pc", first_pc, 32'h0000_0100);

    // 4: redirect coinciding with a response and a dequeue from a nearly full buffer.
    apply_reset();
    lat_min = 3; lat_max = 3;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (buffer.size() == 3 && inflight.size() == 1 && inflight[0].due <= cyc) begin
        step(1'b1, 1'b1, 32'h0000_0040, 1'b1);
        hit = 1'b1;
        break;
      end
      step(1'b1, 1'b0, '0, 1'b0);
    end
    check("t4_scenario_hit", 32'(hit), 32'd1);
    #1 check("t4_out_valid", out_valid, 32'd0);

    // 5: grant withheld keeps the address stable; dropping fetch_en still delivers in-flight words.
    gnt_pct = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);
    #1;
    check("t5_addr_stable", mem_addr, 32'h0000_0040);
    check("t5_req_held", mem_req, 32'd1);
    gnt_pct = 100;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
    exp_deliv = inflight.size() + buffer.size();
    n0 = n_gnt;
    d0 = n_deliv;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b1);
    check("t5_no_grants", 32'(n_gnt - n0), 32'd0);
    check("t5_delivered", 32'(n_deliv - d0), 32'(exp_deliv));

    // 6: reset with two requests outstanding, then a clean restart from RESET_PC.
    apply_reset();
    lat_min = 5; lat_max = 5;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
    apply_reset();
    lat_min = 1; lat_max = 1;
    seen_pc.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);
    first_pc = (seen_pc.size() > 0) ? seen_pc[0] : 32'hDEAD_BEEF;
    check("t6_restart_pc", first_pc, RESET_PC);

    // Address wrap at the top of the space, unaligned target.
    step(1'b1, 1'b1, 32'hFFFF_FFF9, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Randomized traffic: variable grant rate, latency, backpressure, fetch gating and redirects.
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        gnt_pct = $urandom_range(100, 30);
        lat_max = $urandom_range(4, 1);
      end
      step($urandom_range(99) < 90, $urandom_range(99) < 4, 32'($urandom_range(1023, 0)),
           $urandom_range(99) < 70);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
